// File: rtl/impulse_noise_pkg.sv
// -----------------------------------------------------------------------------
// impulse_noise_pkg
//
// Shared definitions for the impulse noise injector and related stimulus
// blocks:
//   - spike mode encodings (mode_e)
//   - injector state encoding (state_e)
//   - Galois tap mask for the x^32+x^22+x^2+x+1 LFSR
//   - saturation limits for a signed 16-bit sample
//   - sat_add(): signed add clamped to a caller-supplied [lo, hi] range
// -----------------------------------------------------------------------------
package impulse_noise_pkg;

    // Sample width the SAT_MAX / SAT_MIN constants correspond to.
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        MODE_ADD_RAND = 2'd0,   // Input +/- SpikeAmp, sign from the LFSR
        MODE_SALT     = 2'd1,   // full-scale positive
        MODE_PEPPER   = 2'd2,   // full-scale negative
        MODE_ADD_POS  = 2'd3    // Input + SpikeAmp
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    // Right-shifting Galois form: bit k of the mask feeds x^(k+1).
    // x^32 -> bit 31, x^22 -> bit 21, x^2 -> bit 1, x^1 -> bit 0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic signed [31:0] SAT_MAX = 32'sd32767;
    localparam logic signed [31:0] SAT_MIN = -32'sd32768;

    // Adds two 32-bit signed values with one guard bit, then clamps to
    // [lo, hi]. Callers sign-extend narrower samples into a and b.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input logic signed [31:0] lo,
        input logic signed [31:0] hi
    );
        logic signed [32:0] sum;
        sum = $signed({a[31], a}) + $signed({b[31], b});
        if (sum > $signed({hi[31], hi})) begin
            return hi;
        end
        if (sum < $signed({lo[31], lo})) begin
            return lo;
        end
        return sum[31:0];
    endfunction

endpackage : impulse_noise_pkg

// File: rtl/lfsr_prng.sv
// -----------------------------------------------------------------------------
// lfsr_prng
//
// Free-running Galois LFSR. Shifts right once per clock; when the bit leaving
// position 0 is set, the tap mask is XORed into the shifted value.
// A zero seed would lock the register at zero, so it is replaced by 1.
//
// Ports:
//   Clk    in   clock
//   Reset  in   synchronous, active-high; loads the seed
//   state  out  WIDTH  current register contents
// -----------------------------------------------------------------------------
module lfsr_prng #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = 32'hACE1_2025,
    parameter logic [WIDTH-1:0] TAPS  = 32'h8020_0003
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] SEED_EFF =
        (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] lfsr_next;

    // Each bit takes its upper neighbour, XORed with the feedback bit
    // wherever the tap mask is set. The top bit has no upper neighbour.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (TAPS[gi] & lfsr_reg[0]);
        end
    endgenerate
    assign lfsr_next[WIDTH-1] = TAPS[WIDTH-1] & lfsr_reg[0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_reg <= SEED_EFF;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign state = lfsr_reg;

endmodule : lfsr_prng

// File: rtl/impulse_noise_injector.sv
// -----------------------------------------------------------------------------
// impulse_noise_injector
//
// Injects programmable bursts of impulsive spikes into a signed sample
// stream. A seeded LFSR drives the burst trigger, so every run repeats
// exactly. Each burst is BurstLen spiked samples (0 -> 1, clamped to
// MAX_BURST), followed by Holdoff forced-clean samples.
//
// Ports:
//   Clk          in   sample clock
//   Reset        in   synchronous, active-high
//   Input        in   DATA_W     clean sample (signed)
//   Enable       in   1          injection enable; low = clean passthrough
//   Threshold    in   16         burst starts when LFSR[15:0] < Threshold
//   Mode         in   2          spike mode (see mode_e)
//   SpikeAmp     in   DATA_W-1   spike magnitude for the additive modes
//   BurstLen     in   3          spiked samples per burst
//   Holdoff      in   HOLDOFF_W  clean samples forced after a burst
//   Output       out  DATA_W     registered, possibly spiked sample
//   SpikeActive  out  1          high when Output is a spike
//   SpikeCount   out  32         bursts started, saturating
//
// Both the clean and spiked paths go through the same output register, so
// latency is one cycle either way.
// -----------------------------------------------------------------------------
module impulse_noise_injector
    import impulse_noise_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter logic [31:0] SEED      = 32'hACE1_2025,
    parameter int          MAX_BURST = 7,
    parameter int          HOLDOFF_W = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [DATA_W-1:0]    Input,
    input  logic                 Enable,
    input  logic [15:0]          Threshold,
    input  logic [1:0]           Mode,
    input  logic [DATA_W-2:0]    SpikeAmp,
    input  logic [2:0]           BurstLen,
    input  logic [HOLDOFF_W-1:0] Holdoff,
    output logic [DATA_W-1:0]    Output,
    output logic                 SpikeActive,
    output logic [31:0]          SpikeCount
);

    // Output range for DATA_W; the package limits cover the 16-bit default.
    localparam logic signed [31:0] OUT_MAX = (DATA_W == DATA_W_DEF) ? SAT_MAX :
                                             $signed((32'd1 << (DATA_W - 1)) - 32'd1);
    localparam logic signed [31:0] OUT_MIN = -OUT_MAX - 32'sd1;

    // BurstLen is only 3 bits wide, so the usable clamp is 1..7.
    localparam logic [2:0] MAX_LEN = (MAX_BURST >= 7) ? 3'd7 :
                                     (MAX_BURST <= 1) ? 3'd1 : 3'(MAX_BURST);

    localparam logic [HOLDOFF_W-1:0] HOLD_ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Pseudo-random source
    // -------------------------------------------------------------------------
    logic [31:0] lfsr_state;
    logic [15:0] rnd;
    logic        rnd_neg;
    logic        unused_lfsr_bits;

    lfsr_prng #(
        .WIDTH (32),
        .SEED  (SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .state (lfsr_state)
    );

    assign rnd              = lfsr_state[15:0];
    assign rnd_neg          = lfsr_state[31];
    assign unused_lfsr_bits = ^lfsr_state[30:16];

    // -------------------------------------------------------------------------
    // State and burst parameters
    // -------------------------------------------------------------------------
    state_e                 state_reg,     state_next;
    logic [2:0]             burst_cnt_reg, burst_cnt_next;   // spikes left after this one
    logic [HOLDOFF_W-1:0]   hold_cnt_reg,  hold_cnt_next;    // clean samples left
    logic [HOLDOFF_W-1:0]   hold_lat_reg,  hold_lat_next;    // Holdoff captured at burst start
    mode_e                  mode_lat_reg,  mode_lat_next;
    logic [DATA_W-2:0]      amp_lat_reg,   amp_lat_next;
    logic                   neg_lat_reg,   neg_lat_next;
    logic [31:0]            spike_cnt_reg, spike_cnt_next;

    logic [DATA_W-1:0]      out_reg,       out_next;
    logic                   active_reg,    active_next;

    logic                   trigger;
    logic [2:0]             eff_len;
    mode_e                  mode_in;
    logic                   neg_in;

    assign trigger = Enable && (rnd < Threshold);
    assign eff_len = (BurstLen == 3'd0)   ? 3'd1    :
                     (BurstLen > MAX_LEN) ? MAX_LEN : BurstLen;
    assign mode_in = mode_e'(Mode);
    assign neg_in  = (mode_in == MODE_ADD_POS) ? 1'b0 : rnd_neg;

    // -------------------------------------------------------------------------
    // State register (also holds the output stage)
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            burst_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
            hold_lat_reg  <= '0;
            mode_lat_reg  <= MODE_ADD_RAND;
            amp_lat_reg   <= '0;
            neg_lat_reg   <= 1'b0;
            spike_cnt_reg <= '0;
            out_reg       <= '0;
            active_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
            hold_lat_reg  <= hold_lat_next;
            mode_lat_reg  <= mode_lat_next;
            amp_lat_reg   <= amp_lat_next;
            neg_lat_reg   <= neg_lat_next;
            spike_cnt_reg <= spike_cnt_next;
            out_reg       <= out_next;
            active_reg    <= active_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        hold_lat_next  = hold_lat_reg;
        mode_lat_next  = mode_lat_reg;
        amp_lat_next   = amp_lat_reg;
        neg_lat_next   = neg_lat_reg;
        spike_cnt_next = spike_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (trigger) begin
                    // The triggering sample is the first spike of the burst;
                    // the counter holds how many more follow it.
                    mode_lat_next  = mode_in;
                    amp_lat_next   = SpikeAmp;
                    neg_lat_next   = neg_in;
                    hold_lat_next  = Holdoff;
                    burst_cnt_next = eff_len - 3'd1;
                    if (spike_cnt_reg != 32'hFFFF_FFFF) begin
                        spike_cnt_next = spike_cnt_reg + 32'd1;
                    end
                    if (eff_len != 3'd1) begin
                        state_next = ST_BURST;
                    end else if (Holdoff != '0) begin
                        state_next    = ST_HOLDOFF;
                        hold_cnt_next = Holdoff;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_BURST: begin
                if (!Enable) begin
                    state_next     = ST_IDLE;
                    burst_cnt_next = '0;
                    hold_cnt_next  = '0;
                end else begin
                    burst_cnt_next = burst_cnt_reg - 3'd1;
                    if (burst_cnt_reg <= 3'd1) begin
                        if (hold_lat_reg != '0) begin
                            state_next    = ST_HOLDOFF;
                            hold_cnt_next = hold_lat_reg;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end

            ST_HOLDOFF: begin
                if (!Enable) begin
                    state_next     = ST_IDLE;
                    burst_cnt_next = '0;
                    hold_cnt_next  = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg - HOLD_ONE;
                    if (hold_cnt_reg <= HOLD_ONE) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next     = ST_IDLE;
                burst_cnt_next = '0;
                hold_cnt_next  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    logic                    spike_now;
    mode_e                   sel_mode;
    logic [DATA_W-2:0]       sel_amp;
    logic                    sel_neg;
    logic signed [31:0]      in_ext;
    logic signed [31:0]      amp_ext;
    logic signed [31:0]      sum_sat;
    logic [DATA_W-1:0]       spike_val;

    always_comb begin
        spike_now = 1'b0;
        sel_mode  = mode_lat_reg;
        sel_amp   = amp_lat_reg;
        sel_neg   = neg_lat_reg;

        // The first spike of a burst uses the live configuration (it is being
        // latched on this edge); the rest of the burst uses the latched copy.
        if (state_reg == ST_IDLE) begin
            spike_now = trigger;
            sel_mode  = mode_in;
            sel_amp   = SpikeAmp;
            sel_neg   = neg_in;
        end else if (state_reg == ST_BURST) begin
            spike_now = Enable;
        end

        in_ext  = $signed({{(32-DATA_W){Input[DATA_W-1]}}, Input});
        amp_ext = $signed({{(33-DATA_W){1'b0}}, sel_amp});
        sum_sat = sat_add(in_ext, sel_neg ? -amp_ext : amp_ext, OUT_MIN, OUT_MAX);

        case (sel_mode)
            MODE_SALT:   spike_val = OUT_MAX[DATA_W-1:0];
            MODE_PEPPER: spike_val = OUT_MIN[DATA_W-1:0];
            default:     spike_val = sum_sat[DATA_W-1:0];
        endcase

        out_next    = spike_now ? spike_val : Input;
        active_next = spike_now;
    end

    assign Output      = out_reg;
    assign SpikeActive = active_reg;
    assign SpikeCount  = spike_cnt_reg;

endmodule : impulse_noise_injector

// File: tb/tb_impulse_noise_injector.sv
// -----------------------------------------------------------------------------
// tb_impulse_noise_injector
//
// Scoreboard bench. The stimulus process drives one sample per cycle, runs a
// behavioural reference of the injector (its own LFSR seeded with SEED) and
// queues the expected Output / SpikeActive / SpikeCount for the following
// cycle. An independent monitor pops one entry per cycle on the falling edge
// and compares. Median entries additionally feed a 5-tap moving median of the
// DUT output, which must stay at the clean input value.
// -----------------------------------------------------------------------------
module tb_impulse_noise_injector;

    localparam logic [31:0] SEED  = 32'hACE1_2025;
    localparam int          MAX_B = 7;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Input;
    logic        Enable;
    logic [15:0] Threshold;
    logic [1:0]  Mode;
    logic [14:0] SpikeAmp;
    logic [2:0]  BurstLen;
    logic [7:0]  Holdoff;
    logic [15:0] Output;
    logic        SpikeActive;
    logic [31:0] SpikeCount;

    impulse_noise_injector #(
        .DATA_W    (16),
        .SEED      (SEED),
        .MAX_BURST (MAX_B),
        .HOLDOFF_W (8)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Input       (Input),
        .Enable      (Enable),
        .Threshold   (Threshold),
        .Mode        (Mode),
        .SpikeAmp    (SpikeAmp),
        .BurstLen    (BurstLen),
        .Holdoff     (Holdoff),
        .Output      (Output),
        .SpikeActive (SpikeActive),
        .SpikeCount  (SpikeCount)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] out;
        logic        act;
        logic [31:0] cnt;
        bit          med;
        logic [63:0] tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model state
    int          m_state;    // 0 idle, 1 burst, 2 holdoff
    int          m_left;
    int          m_hcnt;
    int          m_hold;
    int          p_mode;
    int          p_amp;
    bit          p_neg;
    logic [31:0] m_lfsr;
    logic [31:0] m_cnt;

    task automatic step(input logic [63:0] tag, input bit med);
        exp_t        e;
        int          s_in;
        int          val;
        int          len;
        bit          spk;
        logic [15:0] rnd;
        e.due = cyc + 1;
        e.tag = tag;
        e.med = med;
        if (Reset) begin
            m_state = 0; m_left = 0; m_hcnt = 0; m_hold = 0;
            m_cnt   = 32'd0;
            m_lfsr  = SEED;
            e.out = 16'd0; e.act = 1'b0; e.cnt = 32'd0;
        end else begin
            rnd = m_lfsr[15:0];
            spk = 1'b0;
            if (m_state == 0) begin
                if (Enable && rnd < Threshold) begin
                    spk    = 1'b1;
                    p_mode = int'(Mode);
                    p_amp  = int'(SpikeAmp);
                    p_neg  = (Mode == 2'd3) ? 1'b0 : m_lfsr[31];
                    len    = (BurstLen == 3'd0) ? 1 :
                             ((int'(BurstLen) > MAX_B) ? MAX_B : int'(BurstLen));
                    m_left = len - 1;
                    m_hold = int'(Holdoff);
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                    if (m_left > 0) m_state = 1;
                    else if (m_hold > 0) begin m_state = 2; m_hcnt = m_hold; end
                end
            end else if (!Enable) begin
                m_state = 0; m_left = 0; m_hcnt = 0;
            end else if (m_state == 1) begin
                spk    = 1'b1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_hold > 0) begin m_state = 2; m_hcnt = m_hold; end
                    else m_state = 0;
                end
            end else begin
                m_hcnt = m_hcnt - 1;
                if (m_hcnt == 0) m_state = 0;
            end
            s_in = int'($signed(Input));
            if (p_mode == 1)      val = 32767;
            else if (p_mode == 2) val = -32768;
            else begin
                val = p_neg ? s_in - p_amp : s_in + p_amp;
                if (val > 32767)  val = 32767;
                if (val < -32768) val = -32768;
            end
            e.out = spk ? 16'(val) : Input;
            e.act = spk;
            e.cnt = m_cnt;
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
        end
        q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step("reset", 1'b0);
        Reset = 1'b0;
    endtask

    // Advance until the model has started a burst; a missing start is a failure.
    task automatic run_to_burst(input logic [63:0] tag);
        int n;
        n = 0;
        while (m_state != 1 && n < 200) begin
            step(tag, 1'b0);
            n++;
        end
        checks++;
        if (m_state == 1) passes++;
        else $display("FAIL %s burst-start: got no burst within %0d cycles, required a burst", tag, n);
    endtask

    function automatic int med5(input int a[5]);
        int t[5];
        int tmp;
        t = a;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 4 - i; j++)
                if (t[j] > t[j+1]) begin tmp = t[j]; t[j] = t[j+1]; t[j+1] = tmp; end
        return t[2];
    endfunction

    // Monitor / scoreboard
    int win[5];
    int win_n = 0;
    always @(negedge Clk) begin
        exp_t e;
        int   m;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            checks++;
            if (Output === e.out) passes++;
            else $display("FAIL %s out cyc=%0d got %0d required %0d", e.tag, cyc,
                          $signed(Output), $signed(e.out));
            checks++;
            if (SpikeActive === e.act) passes++;
            else $display("FAIL %s spike_active cyc=%0d got %b required %b", e.tag, cyc,
                          SpikeActive, e.act);
            checks++;
            if (SpikeCount === e.cnt) passes++;
            else $display("FAIL %s spike_count cyc=%0d got %0d required %0d", e.tag, cyc,
                          SpikeCount, e.cnt);
            if (e.med) begin
                for (int i = 4; i > 0; i--) win[i] = win[i-1];
                win[0] = int'($signed(Output));
                if (win_n < 5) win_n++;
                if (win_n == 5) begin
                    m = med5(win);
                    checks++;
                    if (m == -1234) passes++;
                    else $display("FAIL median cyc=%0d got %0d required -1234", cyc, m);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1; Enable = 1'b0; Input = 16'd0; Threshold = 16'd0;
        Mode = 2'd0; SpikeAmp = 15'd0; BurstLen = 3'd1; Holdoff = 8'd0;
        repeat (3) step("reset", 1'b0);
        Reset = 1'b0;

        // Threshold 0 never triggers: ramp passes straight through.
        Enable = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            Input = 16'(i);
            step("pass", 1'b0);
        end

        // Salt bursts of 2 with holdoff 3 on a constant input.
        do_reset();
        Mode = 2'd1; Threshold = 16'hFFFF; BurstLen = 3'd2; Holdoff = 8'd3; Input = 16'd1000;
        repeat (40) step("salt", 1'b0);

        // Saturating additive spikes.
        do_reset();
        Mode = 2'd3; SpikeAmp = 15'd10000; Input = 16'd30000; BurstLen = 3'd1; Holdoff = 8'd0;
        repeat (10) step("satpos", 1'b0);
        Mode = 2'd0; Input = 16'(-30000);
        repeat (20) step("satneg", 1'b0);
        Input = 16'd100; SpikeAmp = 15'd50;
        repeat (20) step("small", 1'b0);

        // Burst length clamping: 0 -> 1, 7 -> 7.
        Mode = 2'd2; Input = 16'd7; BurstLen = 3'd0; Holdoff = 8'd2;
        repeat (20) step("len0", 1'b0);
        BurstLen = 3'd7; Holdoff = 8'd1;
        repeat (30) step("len7", 1'b0);

        // Enable dropped on the second spike of a 5-sample burst.
        do_reset();
        Mode = 2'd1; BurstLen = 3'd5; Holdoff = 8'd2; Input = 16'd555; Enable = 1'b1;
        run_to_burst("endrop");
        Enable = 1'b0;
        repeat (3) step("endrop", 1'b0);
        Enable = 1'b1;
        repeat (10) step("rearm", 1'b0);

        // Reset during a burst restarts everything, including the LFSR.
        do_reset();
        run_to_burst("rstmid");
        Reset = 1'b1;
        step("rstmid", 1'b0);
        Reset = 1'b0;
        repeat (20) step("rstmid", 1'b0);

        // Configuration changing every cycle: only burst-start values count.
        do_reset();
        Threshold = 16'h3000;
        for (int i = 0; i < 200; i++) begin
            Mode     = 2'(i);
            SpikeAmp = 15'(i * 131);
            BurstLen = 3'(i / 3);
            Holdoff  = 8'(i % 4);
            Input    = 16'(i * 300 - 30000);
            Enable   = (i % 23) != 0;
            step("mixed", 1'b0);
        end

        // Feed a 5-tap moving median: at most 2 spikes per 5 samples.
        do_reset();
        Enable = 1'b1; Mode = 2'd1; Threshold = 16'hFFFF; BurstLen = 3'd2; Holdoff = 8'd3;
        Input = 16'(-1234);
        repeat (40) step("median", 1'b1);

        repeat (2) @(posedge Clk);
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending entries, required 0", q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_impulse_noise_injector
